matmul_result_reader: RTL and testbench

Unloads the 8x8 result matrix from the matrix multiplier's result RAM once the multiplier pulses `done`. It streams the elements row-major onto a valid/ready output, tagging each with its row and column and marking the last element. It sits between the multiplier and any downstream consumer such as a DMA engine, checker or host FIFO. It absorbs the RAM's 1-cycle read latency and downstream backpressure with a 2-entry skid FIFO.

---
 rtl/matmul_pkg.sv | 14 +
 rtl/matmul_result_reader_skid_fifo2.sv | 73 +++++++
 rtl/matmul_result_reader.sv | 147 ++++++++++++++
 tb/tb_matmul_result_reader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix multiplier and its result reader.
package matmul_pkg;

    localparam int N  = 8;
    localparam int CW = 32;
    localparam int AW = $clog2(N * N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } reader_state_e;

endpackage

// File: rtl/matmul_result_reader_skid_fifo2.sv
// Two-entry FIFO whose head entry drives the outputs straight from a register.
module skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic [1:0]   count
);

    logic [W-1:0] head_r, tail_r, head_next_s, tail_next_s;
    logic [1:0]   cnt_r, cnt_next_s;
    logic         valid_r;
    logic         do_pop_s, do_push_s;

    // Next contents: the head always holds the oldest entry, the tail the younger one.
    always_comb begin
        head_next_s = head_r;
        tail_next_s = tail_r;
        cnt_next_s  = cnt_r;
        do_pop_s    = pop && (cnt_r != 2'd0);
        do_push_s   = push && ((cnt_r != 2'd2) || do_pop_s);
        case ({do_push_s, do_pop_s})
            2'b10: begin
                if (cnt_r == 2'd0) begin
                    head_next_s = din;
                end else begin
                    tail_next_s = din;
                end
                cnt_next_s = cnt_r + 2'd1;
            end
            2'b01: begin
                head_next_s = tail_r;
                cnt_next_s  = cnt_r - 2'd1;
            end
            2'b11: begin
                if (cnt_r == 2'd1) begin
                    head_next_s = din;
                end else begin
                    head_next_s = tail_r;
                    tail_next_s = din;
                end
            end
            default: begin
                cnt_next_s = cnt_r;
            end
        endcase
    end

    // Storage, occupancy and registered valid; reset flushes everything to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {W{1'b0}};
            tail_r  <= {W{1'b0}};
            cnt_r   <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            head_r  <= head_next_s;
            tail_r  <= tail_next_s;
            cnt_r   <= cnt_next_s;
            valid_r <= (cnt_next_s != 2'd0);
        end
    end

    assign dout  = head_r;
    assign valid = valid_r;
    assign count = cnt_r;

endmodule

// File: rtl/matmul_result_reader.sv
// Streams the N x N result matrix row-major out of the result RAM after `done`.
// Rows and columns are split straight from the address bits, so N must be a power of two.
module matmul_result_reader #(
    parameter int N  = matmul_pkg::N,
    parameter int CW = matmul_pkg::CW,
    parameter int AW = $clog2(N * N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 done,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    input  logic [CW-1:0]        rd_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [CW-1:0]        m_data,
    output logic [$clog2(N)-1:0] m_row,
    output logic [$clog2(N)-1:0] m_col,
    output logic                 m_last,
    output logic                 busy,
    output logic                 overrun
);
    import matmul_pkg::*;

    localparam int RW = $clog2(N);
    localparam int EW = CW + 2 * RW + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N * N - 1);

    reader_state_e state_r, state_next_s;
    logic [AW-1:0] addr_r, addr_d_r;
    logic          inflight_r, busy_r, overrun_r;
    logic          rd_en_s, pop_s, last_hs_s, start_s;
    logic [1:0]    occ_s, fifo_cnt_s;
    logic          fifo_valid_s;
    logic [EW-1:0] fifo_din_s, fifo_dout_s;

    // Occupancy counts entries left after this cycle's pop plus the read in flight,
    // so a full-rate stream keeps issuing while the FIFO never overfills.
    assign pop_s     = fifo_valid_s & m_ready;
    assign last_hs_s = pop_s & fifo_dout_s[0];
    assign occ_s     = fifo_cnt_s - {1'b0, pop_s} + {1'b0, inflight_r};
    assign rd_en_s   = (state_r == READ) && (occ_s < 2'd2);
    // A done coinciding with the final handshake starts the next frame directly.
    assign start_s   = done && ((state_r == IDLE) || ((state_r == DRAIN) && last_hs_s));

    assign fifo_din_s = {rd_data, addr_d_r[AW-1:RW], addr_d_r[RW-1:0], (addr_d_r == LAST_ADDR)};

    // Frame sequencing: read all addresses, then drain until the last element leaves.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (done) begin
                    state_next_s = READ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ: begin
                if (rd_en_s && (addr_r == LAST_ADDR)) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = READ;
                end
            end
            DRAIN: begin
                if (last_hs_s) begin
                    if (done) begin
                        state_next_s = READ;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register with busy registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // Read address: cleared on frame start, advanced per issued read, parked on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r <= {AW{1'b0}};
        end else if (start_s) begin
            addr_r <= {AW{1'b0}};
        end else if (rd_en_s && (addr_r != LAST_ADDR)) begin
            addr_r <= addr_r + AW'(1'b1);
        end else begin
            addr_r <= addr_r;
        end
    end

    // In-flight tracking: remembers the address of the read whose data returns next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r <= 1'b0;
            addr_d_r   <= {AW{1'b0}};
        end else begin
            inflight_r <= rd_en_s;
            addr_d_r   <= rd_en_s ? addr_r : addr_d_r;
        end
    end

    // Sticky overrun: a done that arrives mid-frame and is not a back-to-back start.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (done && !start_s && (state_r != IDLE)) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    skid_fifo2 #(.W(EW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_r),
        .din   (fifo_din_s),
        .pop   (m_ready),
        .dout  (fifo_dout_s),
        .valid (fifo_valid_s),
        .count (fifo_cnt_s)
    );

    assign rd_en   = rd_en_s;
    assign rd_addr = addr_r;
    assign m_valid = fifo_valid_s;
    assign {m_data, m_row, m_col, m_last} = fifo_dout_s;
    assign busy    = busy_r;
    assign overrun = overrun_r;

endmodule

// File: tb/tb_matmul_result_reader.sv
// Self-checking bench for matmul_result_reader: scenario table plus hand-written corner sequences,
// checked every cycle against a frame-level reference model.
module tb_matmul_result_reader;
    import matmul_pkg::*;

    localparam int NN = N * N;
    localparam int RW = $clog2(N);

    logic clk = 1'b0;
    logic rst, done, rd_en, m_valid, m_ready, m_last, busy, overrun;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] rd_data, m_data;
    logic [RW-1:0] m_row, m_col;

    matmul_result_reader dut (
        .clk(clk), .rst(rst), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row), .m_col(m_col),
        .m_last(m_last), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Result RAM with one cycle of read latency.
    logic [CW-1:0] ram [NN];
    always @(posedge clk) begin
        if (rd_en === 1'b1) rd_data <= ram[rd_addr];
    end

    typedef struct {
        logic [CW-1:0] data;
        logic [RW-1:0] row;
        logic [RW-1:0] col;
        logic          last;
    } beat_t;

    typedef struct {
        int ready_pct;
        int done2_beat;
        int rst_beat;
        bit ramp;
        int exp_beats;
        int exp_lasts;
        bit exp_ovr;
    } vec_t;

    beat_t exp_q[$];
    int pass_cnt = 0, chk_cnt = 0, cyc = 0;
    bit mdl_busy = 0, mdl_ovr = 0, post_rst = 0, prev_stall = 0;
    int issued = 0, accepted = 0, beats = 0, lasts = 0;
    int t_done = 0, t_first_rd = 0, t_first_hs = 0, t_last_hs = 0;
    logic [CW-1:0] p_data;
    logic [RW-1:0] p_row, p_col;
    logic          p_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic load_ram(input bit ramp);
        for (int k = 0; k < NN; k++) ram[k] = ramp ? CW'((k / N) * 16 + (k % N)) : CW'($urandom);
    endtask

    // Expected frame: every element in row-major order, last flag only on the final one.
    task automatic start_frame();
        beat_t b;
        exp_q.delete();
        for (int k = 0; k < NN; k++) begin
            b.data = ram[k];
            b.row  = RW'(k / N);
            b.col  = RW'(k % N);
            b.last = (k == NN - 1);
            exp_q.push_back(b);
        end
        mdl_busy = 1; issued = 0; accepted = 0; t_done = cyc;
    endtask

    // Compare this cycle's outputs with the model, then advance the model by this cycle's events.
    task automatic monitor(input bit rst_v, input bit done_v, input bit rdy_v);
        bit hs, last_hs, was_busy;
        beat_t e;
        if (rst_v) begin
            exp_q.delete();
            mdl_busy = 0; mdl_ovr = 0; issued = 0; accepted = 0; prev_stall = 0; post_rst = 1;
            return;
        end
        if (post_rst) begin
            check("reset rd_en", rd_en, 0);     check("reset rd_addr", rd_addr, 0);
            check("reset m_valid", m_valid, 0); check("reset m_data", m_data, 0);
            check("reset m_row", m_row, 0);     check("reset m_col", m_col, 0);
            check("reset m_last", m_last, 0);   check("reset busy", busy, 0);
            check("reset overrun", overrun, 0);
            post_rst = 0;
        end
        check("busy", busy, mdl_busy);
        check("overrun", overrun, mdl_ovr);
        if (prev_stall) begin
            check("stall m_valid held", m_valid, 1); check("stall m_data held", m_data, p_data);
            check("stall m_row held", m_row, p_row); check("stall m_col held", m_col, p_col);
            check("stall m_last held", m_last, p_last);
        end
        hs = (m_valid === 1'b1) && rdy_v;
        if (rd_en === 1'b1) begin
            check("rd_en only during a frame", mdl_busy, 1);
            check("rd_addr order", rd_addr, issued);
            check("rd_en within FIFO capacity", (issued - accepted - int'(hs)) < 2, 1);
            if (issued == 0) t_first_rd = cyc;
            issued++;
        end
        last_hs = 0;
        if (hs) begin
            check("beat expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("beat %0d data", accepted), m_data, e.data);
                check($sformatf("beat %0d row", accepted), m_row, e.row);
                check($sformatf("beat %0d col", accepted), m_col, e.col);
                check($sformatf("beat %0d last", accepted), m_last, e.last);
                last_hs = e.last;
            end
            if (accepted == 0) t_first_hs = cyc;
            accepted++; beats++;
            if (m_last === 1'b1) begin lasts++; t_last_hs = cyc; end
        end
        was_busy = mdl_busy;
        if (last_hs) mdl_busy = 0;
        if (done_v) begin
            if (!was_busy || last_hs) start_frame();
            else mdl_ovr = 1;
        end
        prev_stall = (m_valid === 1'b1) && !rdy_v;
        p_data = m_data; p_row = m_row; p_col = m_col; p_last = m_last;
    endtask

    // One clock cycle: drive just after the rising edge, check on the falling edge.
    task automatic cycle(input bit rst_v, input bit done_v, input bit rdy_v);
        rst = rst_v; done = done_v; m_ready = rdy_v;
        @(negedge clk);
        monitor(rst_v, done_v, rdy_v);
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic do_reset();
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        beats = 0; lasts = 0;
    endtask

    task automatic run_vec(input vec_t v, output int nb, output int nl);
        bit d, r, rdy, d2_fired, rst_fired, fin;
        do_reset();
        load_ram(v.ramp);
        cycle(0, 1, 0);
        d2_fired = 0; rst_fired = 0; fin = 0;
        for (int i = 0; i < 3000 && !fin; i++) begin
            rdy = ($urandom_range(99) < v.ready_pct);
            d = 0; r = 0;
            if (v.done2_beat >= 0 && !d2_fired && beats >= v.done2_beat) begin d = 1; d2_fired = 1; end
            if (v.rst_beat >= 0 && !rst_fired && beats >= v.rst_beat) begin r = 1; rdy = 0; rst_fired = 1; end
            cycle(r, d, rdy);
            if (r) begin
                cycle(0, 0, 0);
                cycle(0, 1, 1);
            end
            fin = !mdl_busy && (exp_q.size() == 0);
        end
        check("frame completes within budget", fin, 1);
        repeat (4) cycle(0, 0, 1);
        nb = beats; nl = lasts;
    endtask

    vec_t vecs[6];

    initial begin
        int nb, nl;
        bit fin, b2b, d;
        vecs[0] = '{100, -1, -1, 1, 64, 1, 0};
        vecs[1] = '{30,  -1, -1, 0, 64, 1, 0};
        vecs[2] = '{70,  20, -1, 0, 64, 1, 1};
        vecs[3] = '{30,  20, -1, 1, 64, 1, 1};
        vecs[4] = '{100, -1, 30, 0, 94, 1, 0};
        vecs[5] = '{50,  -1, 30, 1, 94, 1, 0};
        rst = 1; done = 0; m_ready = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], nb, nl);
            check($sformatf("vec%0d beat count", i), nb, vecs[i].exp_beats);
            check($sformatf("vec%0d m_last count", i), nl, vecs[i].exp_lasts);
            check($sformatf("vec%0d overrun", i), overrun, vecs[i].exp_ovr);
        end

        // Basic frame latency with continuous ready.
        do_reset();
        load_ram(1);
        repeat (3) cycle(0, 0, 1);
        cycle(0, 1, 1);
        fin = 0;
        for (int i = 0; i < 200 && !fin; i++) begin
            cycle(0, 0, 1);
            fin = !mdl_busy && (exp_q.size() == 0);
        end
        check("basic frame completes", fin, 1);
        check("basic beats", beats, 64);
        check("basic first rd_en latency", t_first_rd - t_done, 1);
        check("basic first m_valid latency", t_first_hs - t_done, 3);
        check("basic m_last latency", t_last_hs - t_done, 66);
        check("basic busy low cycle", cyc - t_done, 67);
        check("basic busy low", busy, 0);

        // Back-to-back: new done on the cycle of the last handshake.
        do_reset();
        load_ram(0);
        cycle(0, 1, 1);
        b2b = 0; fin = 0;
        for (int i = 0; i < 400 && !fin; i++) begin
            d = 0;
            if (!b2b && m_valid === 1'b1 && m_last === 1'b1) begin d = 1; b2b = 1; end
            cycle(0, d, 1);
            if (d) begin
                check("b2b rd_en next cycle", rd_en, 1);
                check("b2b rd_addr restarts at 0", rd_addr, 0);
                check("b2b overrun clear", overrun, 0);
                check("b2b busy held", busy, 1);
            end
            fin = b2b && !mdl_busy && (exp_q.size() == 0);
        end
        check("b2b both frames complete", fin, 1);
        check("b2b beat count", beats, 128);
        check("b2b m_last count", lasts, 2);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
